if_fetch_unit: RTL and testbench

Instruction-fetch producer that feeds the IF/ID pipeline register. Owns the program counter, issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake, and buffers one fetched instruction. Presents PC+4 and the instruction to the pipeline register. Honours pipeline freeze and branch redirects, including discarding in-flight wrong-path responses.

---
 rtl/if_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch producer for the IF/ID pipeline register.
//               Owns the program counter, keeps at most one request
//               outstanding to instruction memory (req/ready + rvalid) and
//               buffers one fetched instruction. Handles pipeline freeze and
//               branch redirects, dropping wrong-path responses in flight.
// Ports       : clk             - clock, rising edge
//               rst             - synchronous reset, active low
//               freeze          - hold the buffered instruction
//               branch_taken    - redirect request
//               branch_addr     - redirect target
//               imem_req        - memory request
//               imem_addr       - memory request address
//               imem_ready      - memory accepted the request
//               imem_rvalid     - memory response valid
//               imem_rdata      - memory response word
//               valid_out       - buffer holds a valid instruction
//               pc_out          - fetched address + PC_STEP
//               instruction_out - fetched instruction
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_buf_pc;
  logic [31:0] w_buf_pc_next;
  logic [31:0] r_buf_instr;
  logic [31:0] w_buf_instr_next;
  logic        r_drop;
  logic        w_drop_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_buf_pc    <= 32'h0;
      r_buf_instr <= 32'h0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_buf_pc    <= w_buf_pc_next;
      r_buf_instr <= w_buf_instr_next;
      r_drop      <= w_drop_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_buf_pc_next    = r_buf_pc;
    w_buf_instr_next = r_buf_instr;
    w_drop_next      = r_drop;
    imem_req         = 1'b0;
    imem_addr        = r_pc;
    valid_out        = 1'b0;
    pc_out           = 32'h0;
    instruction_out  = 32'h0;

    case (r_state)
      S_REQ: begin
        // A redirect suppresses the request so the stale pc never goes out.
        imem_req = ~branch_taken;
        if (branch_taken) begin
          w_pc_next = branch_addr;
        end else if (imem_ready) begin
          w_state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (r_drop || branch_taken) begin
            // Wrong-path response: throw it away and refetch from pc.
            w_drop_next  = 1'b0;
            w_state_next = S_REQ;
            if (branch_taken) begin
              w_pc_next = branch_addr;
            end
          end else begin
            w_buf_instr_next = imem_rdata;
            w_buf_pc_next    = r_pc + PC_STEP;
            w_pc_next        = r_pc + PC_STEP;
            w_state_next     = S_FULL;
          end
        end else if (branch_taken) begin
          // Response still owed by memory; remember to discard it.
          w_pc_next   = branch_addr;
          w_drop_next = 1'b1;
        end
      end

      S_FULL: begin
        valid_out       = 1'b1;
        pc_out          = r_buf_pc;
        instruction_out = r_buf_instr;
        if (branch_taken) begin
          w_pc_next    = branch_addr;
          w_state_next = S_REQ;
        end else if (!freeze) begin
          w_state_next = S_REQ;
        end
      end

      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. Directed scenarios
//               followed by randomized traffic against a reference model.
//               A second instance with RESET_PC = 32'hFFFF_FFFC shares all
//               inputs to observe PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        valid0, valid1;
  logic [31:0] pco0, pco1;
  logic [31:0] ins0, ins1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] XMASK = 32'hE000_0000;

  if_fetch_unit dut0 (
    .clk(clk), .rst(rst), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(req0), .imem_addr(addr0), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_out(valid0), .pc_out(pco0), .instruction_out(ins0)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut1 (
    .clk(clk), .rst(rst), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(req1), .imem_addr(addr1), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_out(valid1), .pc_out(pco1), .instruction_out(ins1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait fetch of address a starting in a REQ cycle, with nfrz frozen
  // cycles in FULL. The wrap instance trails by 4 bytes when with1 is set.
  task automatic fetch(input logic [31:0] a, input int nfrz, input bit with1);
    freeze = 0; branch_taken = 0; imem_ready = 1; imem_rvalid = 0;
    #1;
    chk("req_req", {31'b0, req0}, 32'd1);
    chk("req_addr", addr0, a);
    if (with1) chk("wrap_addr", addr1, a - 32'd4);
    tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = a ^ XMASK;
    #1;
    chk("wait_req", {31'b0, req0}, 32'd0);
    chk("wait_valid", {31'b0, valid0}, 32'd0);
    tick();
    imem_rvalid = 0;
    for (int i = 0; i < nfrz; i++) begin
      freeze = 1;
      #1;
      chk("frz_valid", {31'b0, valid0}, 32'd1);
      chk("frz_pc", pco0, a + 32'd4);
      chk("frz_instr", ins0, a ^ XMASK);
      chk("frz_req", {31'b0, req0}, 32'd0);
      tick();
    end
    freeze = 0;
    #1;
    chk("full_valid", {31'b0, valid0}, 32'd1);
    chk("full_pc", pco0, a + 32'd4);
    chk("full_instr", ins0, a ^ XMASK);
    if (with1) chk("wrap_pc", pco1, a);
    tick();
  endtask

  // Reference model state: what the fetcher should be doing, in terms of
  // "next address", "a response is owed", "owed response is stale" and
  // "an instruction is waiting to be consumed".
  logic [31:0] m_pc, m_bpc, m_binstr, mem_addr;
  bit          m_infl, m_stale, m_hold;
  int          mem_delay;

  initial begin
    rst = 0; freeze = 0; branch_taken = 0; branch_addr = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    tick(); tick();
    rst = 1;
    #1;
    chk("rst_req", {31'b0, req0}, 32'd1);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_valid", {31'b0, valid0}, 32'd0);
    chk("rst_pc", pco0, 32'h0);
    chk("rst_instr", ins0, 32'h0);
    chk("rst_addr_wrap", addr1, 32'hFFFF_FFFC);

    // Straight-line fetch, freeze on the second instruction.
    fetch(32'h0, 0, 1);
    fetch(32'h4, 4, 1);
    fetch(32'h8, 0, 1);

    // Branch while waiting on a slow response.
    imem_ready = 1;
    #1; chk("bw_addr", addr0, 32'hC);
    tick();
    imem_ready = 0; branch_taken = 1; branch_addr = 32'h100;
    #1; chk("bw_req", {31'b0, req0}, 32'd0);
    tick();
    branch_taken = 0;
    #1; chk("bw_valid1", {31'b0, valid0}, 32'd0);
    tick();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    #1; chk("bw_valid2", {31'b0, valid0}, 32'd0);
    tick();
    imem_rvalid = 0;
    #1; chk("bw_valid3", {31'b0, valid0}, 32'd0);
    fetch(32'h100, 0, 0);

    // Branch in FULL with freeze asserted.
    imem_ready = 1;
    #1; chk("bf_addr", addr0, 32'h104);
    tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 0; freeze = 1; branch_taken = 1; branch_addr = 32'h40;
    #1; chk("bf_valid_pre", {31'b0, valid0}, 32'd1);
    tick();
    freeze = 0; branch_taken = 0;
    #1;
    chk("bf_valid", {31'b0, valid0}, 32'd0);
    chk("bf_req", {31'b0, req0}, 32'd1);
    chk("bf_newaddr", addr0, 32'h40);

    // Reset while a request is outstanding.
    imem_ready = 1;
    tick();
    imem_ready = 0; rst = 0;
    tick();
    rst = 1;
    #1;
    chk("rw_req", {31'b0, req0}, 32'd1);
    chk("rw_addr", addr0, 32'h0);
    chk("rw_addr_wrap", addr1, 32'hFFFF_FFFC);
    chk("rw_valid", {31'b0, valid0}, 32'd0);

    // Randomized traffic against the reference model.
    m_pc = 32'h0; m_infl = 0; m_stale = 0; m_hold = 0;
    m_bpc = 0; m_binstr = 0; mem_addr = 0; mem_delay = 0;
    for (int c = 0; c < 600; c++) begin
      bit exp_req;
      freeze       = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      branch_addr  = $urandom & 32'hFFFF_FFFC;
      imem_ready   = $urandom_range(0, 1) == 1;
      if (m_infl) begin
        imem_rvalid = (mem_delay == 0);
        imem_rdata  = mem_addr ^ XMASK;
      end else begin
        imem_rvalid = ($urandom_range(0, 9) == 0);
        imem_rdata  = $urandom;
      end
      exp_req = !m_hold && !m_infl && !branch_taken;
      #1;
      chk("rnd_valid", {31'b0, valid0}, {31'b0, m_hold});
      chk("rnd_pc", pco0, m_hold ? m_bpc : 32'h0);
      chk("rnd_instr", ins0, m_hold ? m_binstr : 32'h0);
      chk("rnd_req", {31'b0, req0}, {31'b0, exp_req});
      if (exp_req) chk("rnd_addr", addr0, m_pc);

      if (m_hold) begin
        if (branch_taken) begin
          m_hold = 0; m_pc = branch_addr;
        end else if (!freeze) begin
          m_hold = 0;
        end
      end else if (!m_infl) begin
        if (branch_taken) begin
          m_pc = branch_addr;
        end else if (imem_ready) begin
          m_infl = 1; mem_addr = m_pc; mem_delay = $urandom_range(0, 3);
        end
      end else if (imem_rvalid) begin
        m_infl = 0;
        if (m_stale || branch_taken) begin
          m_stale = 0;
          if (branch_taken) m_pc = branch_addr;
        end else begin
          m_hold = 1; m_bpc = m_pc + 32'd4; m_binstr = imem_rdata; m_pc = m_pc + 32'd4;
        end
      end else begin
        mem_delay--;
        if (branch_taken) begin
          m_pc = branch_addr; m_stale = 1;
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
